// File: rtl/seg7_pkg.sv
// Shared types and constants for the DE0 7-segment "L" blink sequencer.
package seg7_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        STEADY    = 3'd1,
        BLINK_ON  = 3'd2,
        BLINK_OFF = 3'd3,
        DONE      = 3'd4
    } state_t;

    localparam logic [1:0] MODE_STEADY = 2'b00;
    localparam logic [1:0] MODE_BLINK  = 2'b01;
    localparam logic [1:0] MODE_BURST  = 2'b10;

    localparam int unsigned CLK_HZ_DEFAULT = 50000000;

endpackage

// File: rtl/seg7_blink_ctrl_prescaler.sv
// Free-running divider producing a one-cycle tick every HALF cycles while run is high.
module tick_prescaler #(
    parameter int unsigned HALF = 4
) (
    input  logic CLK,
    input  logic nRST,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF - 1);

    if (HALF < 2) begin : gHalfCheck
        $error("tick_prescaler: HALF must be at least 2");
    end

    logic [CNT_W-1:0] cnt;

    // Count 0..HALF-1 while running, wrap on the terminal value, hold at 0 otherwise.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (clr || !run) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = run && !clr && (cnt == LAST);

endmodule

// File: rtl/seg7_blink_ctrl.sv
// Mode sequencer driving the "L"/"0" select of the 7-segment decoder:
// steady, continuous blink and counted burst, with start/stop control.
module seg7_blink_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned CLK_HZ    = CLK_HZ_DEFAULT,
    parameter int unsigned BLINK_HZ  = 2,
    parameter int unsigned BURST_CNT = 4
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       start,
    input  logic       stop,
    input  logic [1:0] mode,
    output logic       en,
    output logic       busy,
    output logic       done,
    output logic [3:0] phase_cnt
);

    localparam int unsigned HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam logic [3:0] BURST_LAST = 4'(BURST_CNT);

    if (BURST_CNT < 1 || BURST_CNT > 15) begin : gBurstCheck
        $error("seg7_blink_ctrl: BURST_CNT must be in 1..15");
    end

    state_t     state;
    logic [1:0] modeLat;
    logic       tick;
    logic       run;
    logic       startAcc;

    assign run      = (state == BLINK_ON) || (state == BLINK_OFF);
    assign startAcc = start && !stop && (state == IDLE);

    tick_prescaler #(
        .HALF(HALF)
    ) uPrescaler (
        .CLK (CLK),
        .nRST(nRST),
        .run (run),
        .clr (startAcc),
        .tick(tick)
    );

    // Mode FSM; outputs are assigned alongside the next state so they stay registered.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            modeLat   <= MODE_STEADY;
            en        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            phase_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state <= IDLE;
                en    <= 1'b0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            modeLat   <= mode;
                            phase_cnt <= '0;
                            en        <= 1'b1;
                            busy      <= 1'b1;
                            if (mode == MODE_BLINK || mode == MODE_BURST) begin
                                state <= BLINK_ON;
                            end else begin
                                state <= STEADY;
                            end
                        end
                    end
                    STEADY: begin
                        en   <= 1'b1;
                        busy <= 1'b1;
                    end
                    BLINK_ON: begin
                        if (tick) begin
                            state <= BLINK_OFF;
                            en    <= 1'b0;
                            if (phase_cnt != 4'hF) begin
                                phase_cnt <= phase_cnt + 4'd1;
                            end
                        end
                    end
                    BLINK_OFF: begin
                        if (tick) begin
                            if (modeLat == MODE_BURST && phase_cnt == BURST_LAST) begin
                                state <= DONE;
                                en    <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state <= BLINK_ON;
                                en    <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        en    <= 1'b0;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        en    <= 1'b0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg7_blink_ctrl.sv
// Scoreboard bench for seg7_blink_ctrl with HALF=4 (CLK_HZ=8, BLINK_HZ=1).
module tb_seg7_blink_ctrl;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       start;
    logic       stop;
    logic [1:0] mode;
    logic       en, busy, done;
    logic [3:0] phase_cnt;
    logic       en1, busy1, done1;
    logic [3:0] phase_cnt1;

    logic [6:0] sbq[$];
    logic [6:0] sbq1[$];
    logic [6:0] obs, expv;
    int nCompared = 0;
    int nMismatch = 0;

    seg7_blink_ctrl #(.CLK_HZ(8), .BLINK_HZ(1), .BURST_CNT(2)) dut (
        .CLK(CLK), .nRST(nRST), .start(start), .stop(stop), .mode(mode),
        .en(en), .busy(busy), .done(done), .phase_cnt(phase_cnt)
    );

    seg7_blink_ctrl #(.CLK_HZ(8), .BLINK_HZ(1), .BURST_CNT(1)) dut1 (
        .CLK(CLK), .nRST(nRST), .start(start), .stop(stop), .mode(mode),
        .en(en1), .busy(busy1), .done(done1), .phase_cnt(phase_cnt1)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [6:0] pack(input logic e, input logic b, input logic d, input int p);
        return {e, b, d, 4'(p)};
    endfunction

    task automatic test_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK) nRST = 1'b1;
        step();
        mode = 2'b00; start = 1'b1;
        sbq.push_back(pack(1, 1, 0, 0));
        step();
        start = 1'b0;
        obs = {en, busy, done, phase_cnt}; expv = sbq.pop_front(); nCompared++;
        if (obs !== expv) begin nMismatch++; $display("FAIL reset_pre: got %b required %b", obs, expv); end
        @(negedge CLK) nRST = 1'b0;
        #1;
        sbq.push_back(pack(0, 0, 0, 0));
        obs = {en, busy, done, phase_cnt}; expv = sbq.pop_front(); nCompared++;
        if (obs !== expv) begin nMismatch++; $display("FAIL reset_async: got %b required %b", obs, expv); end
        for (int i = 0; i < 3; i++) begin
            sbq.push_back(pack(0, 0, 0, 0));
            step();
            obs = {en, busy, done, phase_cnt}; expv = sbq.pop_front(); nCompared++;
            if (obs !== expv) begin nMismatch++; $display("FAIL reset_hold[%0d]: got %b required %b", i, obs, expv); end
        end
        @(negedge CLK) nRST = 1'b1;
        sbq.push_back(pack(0, 0, 0, 0));
        step();
        obs = {en, busy, done, phase_cnt}; expv = sbq.pop_front(); nCompared++;
        if (obs !== expv) begin nMismatch++; $display("FAIL reset_release: got %b required %b", obs, expv); end
    endtask

    task automatic test_steady(input logic [1:0] m, input string tag);
        mode = m;
        for (int i = 0; i < 21; i++) begin
            start = (i == 0);
            sbq.push_back(pack(1, 1, 0, 0));
            step();
            start = 1'b0;
            obs = {en, busy, done, phase_cnt}; expv = sbq.pop_front(); nCompared++;
            if (obs !== expv) begin nMismatch++; $display("FAIL %s_run[%0d]: got %b required %b", tag, i, obs, expv); end
        end
        for (int i = 0; i < 4; i++) begin
            stop = (i == 0);
            sbq.push_back(pack(0, 0, 0, 0));
            step();
            stop = 1'b0;
            obs = {en, busy, done, phase_cnt}; expv = sbq.pop_front(); nCompared++;
            if (obs !== expv) begin nMismatch++; $display("FAIL %s_stop[%0d]: got %b required %b", tag, i, obs, expv); end
        end
    endtask

    task automatic test_continuous();
        mode = 2'b01;
        for (int i = 0; i < 32; i++) begin
            start = (i == 0);
            if (i == 10) mode = 2'b10;
            sbq.push_back(pack(((i / 4) % 2) == 0, 1, 0, (i + 4) / 8));
            step();
            start = 1'b0;
            obs = {en, busy, done, phase_cnt}; expv = sbq.pop_front(); nCompared++;
            if (obs !== expv) begin nMismatch++; $display("FAIL continuous[%0d]: got %b required %b", i, obs, expv); end
        end
        stop = 1'b1;
        sbq.push_back(pack(0, 0, 0, 4));
        step();
        stop = 1'b0;
        obs = {en, busy, done, phase_cnt}; expv = sbq.pop_front(); nCompared++;
        if (obs !== expv) begin nMismatch++; $display("FAIL continuous_stop: got %b required %b", obs, expv); end
    endtask

    task automatic test_burst();
        mode = 2'b10;
        for (int i = 0; i < 19; i++) begin
            start = (i == 0);
            if (i < 16)       sbq.push_back(pack(((i / 4) % 2) == 0, 1, 0, (i + 4) / 8));
            else if (i == 16) sbq.push_back(pack(0, 1, 1, 2));
            else              sbq.push_back(pack(0, 0, 0, 2));
            step();
            start = 1'b0;
            obs = {en, busy, done, phase_cnt}; expv = sbq.pop_front(); nCompared++;
            if (obs !== expv) begin nMismatch++; $display("FAIL burst[%0d]: got %b required %b", i, obs, expv); end
        end
    endtask

    task automatic test_collisions();
        start = 1'b1; stop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sbq.push_back(pack(0, 0, 0, 2));
            step();
            start = 1'b0; stop = 1'b0;
            obs = {en, busy, done, phase_cnt}; expv = sbq.pop_front(); nCompared++;
            if (obs !== expv) begin nMismatch++; $display("FAIL start_stop_idle[%0d]: got %b required %b", i, obs, expv); end
        end
        mode = 2'b01;
        for (int i = 0; i < 14; i++) begin
            start = (i == 0) || (i == 5);
            stop  = (i == 12);
            if (i < 12)       sbq.push_back(pack(((i / 4) % 2) == 0, 1, 0, (i + 4) / 8));
            else              sbq.push_back(pack(0, 0, 0, 1));
            step();
            start = 1'b0; stop = 1'b0;
            obs = {en, busy, done, phase_cnt}; expv = sbq.pop_front(); nCompared++;
            if (obs !== expv) begin nMismatch++; $display("FAIL collision[%0d]: got %b required %b", i, obs, expv); end
        end
    endtask

    task automatic test_edge_params();
        test_steady(2'b11, "mode11");
        mode = 2'b10;
        for (int i = 0; i < 11; i++) begin
            start = (i == 0);
            if (i < 4)       sbq1.push_back(pack(1, 1, 0, 0));
            else if (i < 8)  sbq1.push_back(pack(0, 1, 0, 1));
            else if (i == 8) sbq1.push_back(pack(0, 1, 1, 1));
            else             sbq1.push_back(pack(0, 0, 0, 1));
            step();
            start = 1'b0;
            obs = {en1, busy1, done1, phase_cnt1}; expv = sbq1.pop_front(); nCompared++;
            if (obs !== expv) begin nMismatch++; $display("FAIL burst1[%0d]: got %b required %b", i, obs, expv); end
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    initial begin
        nRST = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'b00;
        test_reset();
        test_steady(2'b00, "steady");
        test_continuous();
        test_burst();
        test_collisions();
        test_edge_params();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
